// File: rtl/sodor_dmem_responder_pkg.sv
// Shared types and constants for the Sodor data-memory responder:
// memory-type codes, load/store function codes, FSM states, request payload.
package sodor_dmem_responder_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned NBYTES = BUS_W / 8;
  localparam int unsigned TYP_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [TYP_W-1:0] MT_B  = 3'd1;
  localparam logic [TYP_W-1:0] MT_H  = 3'd2;
  localparam logic [TYP_W-1:0] MT_W  = 3'd3;
  localparam logic [TYP_W-1:0] MT_BU = 3'd5;
  localparam logic [TYP_W-1:0] MT_HU = 3'd6;

  localparam logic FCN_LD = 1'b0;
  localparam logic FCN_ST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
    logic             fcn;
    logic [TYP_W-1:0] typ;
  } mem_req_t;

  // Codes 0, 4 and 7 are not defined memory types.
  function automatic logic typ_is_legal(input logic [TYP_W-1:0] typ);
    case (typ)
      MT_B, MT_H, MT_W, MT_BU, MT_HU: typ_is_legal = 1'b1;
      default:                        typ_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sodor_lane_align.sv
// Combinational lane handling: load extract/extend, store replication,
// byte-mask generation and misalignment / illegal-type detection.
module sodor_lane_align
  import sodor_dmem_responder_pkg::*;
(
  input  logic [1:0]        byte_off_i,
  input  logic [TYP_W-1:0]  typ_i,
  input  logic [BUS_W-1:0]  st_data_i,
  input  logic [BUS_W-1:0]  rd_word_i,
  output logic [BUS_W-1:0]  ld_data_c_o,
  output logic [BUS_W-1:0]  wr_data_c_o,
  output logic [NBYTES-1:0] wr_mask_c_o,
  output logic              err_c_o
);

  logic [BUS_W-1:0] shifted;

  always_comb begin
    shifted     = rd_word_i >> {byte_off_i, 3'b000};
    ld_data_c_o = '0;
    wr_data_c_o = '0;
    wr_mask_c_o = '0;
    err_c_o     = !typ_is_legal(typ_i);

    case (typ_i)
      MT_B: begin
        ld_data_c_o = {{(BUS_W-8){shifted[7]}}, shifted[7:0]};
        wr_data_c_o = {NBYTES{st_data_i[7:0]}};
        wr_mask_c_o = NBYTES'(1) << byte_off_i;
      end
      MT_BU: begin
        ld_data_c_o = {{(BUS_W-8){1'b0}}, shifted[7:0]};
        wr_data_c_o = {NBYTES{st_data_i[7:0]}};
        wr_mask_c_o = NBYTES'(1) << byte_off_i;
      end
      MT_H: begin
        err_c_o     = byte_off_i[0];
        ld_data_c_o = {{(BUS_W-16){shifted[15]}}, shifted[15:0]};
        wr_data_c_o = {(NBYTES/2){st_data_i[15:0]}};
        wr_mask_c_o = NBYTES'(3) << byte_off_i;
      end
      MT_HU: begin
        err_c_o     = byte_off_i[0];
        ld_data_c_o = {{(BUS_W-16){1'b0}}, shifted[15:0]};
        wr_data_c_o = {(NBYTES/2){st_data_i[15:0]}};
        wr_mask_c_o = NBYTES'(3) << byte_off_i;
      end
      MT_W: begin
        err_c_o     = (byte_off_i != 2'b00);
        ld_data_c_o = shifted;
        wr_data_c_o = st_data_i;
        wr_mask_c_o = '1;
      end
      default: ;
    endcase

    // An erroring request returns zero and never touches storage.
    if (err_c_o) begin
      ld_data_c_o = '0;
      wr_mask_c_o = '0;
    end
  end

endmodule

// File: rtl/sodor_dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, private
// word-addressed storage, registered response pulse LATENCY cycles after accept.
module sodor_dmem_responder
  import sodor_dmem_responder_pkg::*;
#(
  parameter int unsigned DATA_W  = BUS_W,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_fcn_i,
  input  logic [TYP_W-1:0]  req_typ_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mem_req_t            req_q, req_d;
  logic                accept_c;
  logic                enter_resp_c;

  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;

  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_idx_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [NBYTES-1:0]   wr_mask_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]   idx_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   ld_data_c;
  logic [DATA_W-1:0]   wr_data_c;
  logic [NBYTES-1:0]   wr_mask_c;
  logic                err_c;
  logic                unused_addr_hi;

  // Next-state, counter and request latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    accept_c     = req_valid_i && req_ready_q && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d.addr = req_addr_i;
          req_d.data = req_data_i;
          req_d.fcn  = req_fcn_i;
          req_d.typ  = req_typ_i;
          cnt_d      = CNT_W'(1);
          if (LATENCY == 1) state_d = ST_RESP;
          else              state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) state_d = ST_RESP;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    enter_resp_c = (state_d == ST_RESP);
  end

  // Storage is stable while a request is outstanding, so reading on entry to
  // RESP sees the same word as reading during it (and covers LATENCY=1).
  assign idx_c          = req_d.addr[ADDR_W+1:2];
  assign rd_word_c      = mem_q[idx_c];
  assign unused_addr_hi = ^req_d.addr[BUS_W-1:ADDR_W+2];

  sodor_lane_align u_lane_align (
    .byte_off_i  (req_d.addr[1:0]),
    .typ_i       (req_d.typ),
    .st_data_i   (req_d.data),
    .rd_word_i   (rd_word_c),
    .ld_data_c_o (ld_data_c),
    .wr_data_c_o (wr_data_c),
    .wr_mask_c_o (wr_mask_c),
    .err_c_o     (err_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      req_ready_q  <= (state_d == ST_IDLE);
      resp_valid_q <= enter_resp_c;
      resp_data_q  <= (enter_resp_c && req_d.fcn == FCN_LD) ? ld_data_c : '0;
      resp_err_q   <= enter_resp_c && err_c;
      wr_en_q      <= enter_resp_c && (req_d.fcn == FCN_ST) && !err_c;
      wr_idx_q     <= idx_c;
      wr_data_q    <= wr_data_c;
      wr_mask_q    <= wr_mask_c;
    end
  end

  // Store commits on the edge that ends RESP; a reset on that edge drops it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_RESP && wr_en_q) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_mask_q[b]) mem_q[wr_idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

endmodule
